seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Downstream display stage for the Game block: takes four hex digit values plus decimal-point and digit-enable masks and time-multiplexes them onto the board's 4-digit common-anode seven-segment display (seg/an).
- Double-buffered, so a new frame is applied only at a scan-frame boundary (no tearing).
- Fixed inter-digit blanking interval suppresses ghosting.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range ≥ 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < CLK_DIV.

Ports:
- Clk100Mhz  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- digits  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- dp_in  input  4  decimal point per digit, 1 = lit.
- digit_en  input  4  per-digit enable, 0 = digit stays dark.
- load  input  1  one-cycle strobe: capture digits/dp_in/digit_en into the pending buffer.
- seg  output  8  active-low segments, {dp,g,f,e,d,c,b,a}.
- an  output  4  active-low anodes, an[i] selects digit i.
- frame_tick  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - seg = 8'hFF, an = 4'hF, frame_tick = 0.
  - Prescaler = 0, digit index = 0.
  - Active buffer = all zero, including digit_en = 0, so the display is dark.
  - Pending buffer cleared, pending_valid = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - On the wrap cycle (prescaler == CLK_DIV-1), the digit index advances 0→1→2→3→0.
- Frame boundary: the wrap cycle on which the index goes 3→0.
  - frame_tick is registered and high for exactly the following cycle.
- Buffering:
  - load = 1 writes the inputs into the pending buffer and sets pending_valid. Multiple loads within a frame: the last one wins.
  - At a frame boundary with pending_valid = 1: pending is copied to active and pending_valid is cleared.
  - load on the same cycle as a frame boundary: that cycle's input data goes straight to active and pending_valid ends at 0.
- Output selection (registered; seg/an reflect the prescaler/index state with 1 cycle latency):
  - prescaler < BLANK_CYCLES: an = 4'hF, seg = 8'hFF.
  - Otherwise, if active digit_en[index] = 1:
    - an = ~(4'b0001 << index).
    - seg[6:0] = hex decode of active nibble[index].
    - seg[7] = ~active dp[index].
  - Otherwise: an = 4'hF, seg = 8'hFF.
- Hex decode, 8-bit values with dp off:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
- Invariants:
  - At most one an bit is low in any cycle.
  - an is never low while in the blanking window.
- Reset mid-scan: outputs go dark immediately (asynchronous), index returns to 0, pending data is discarded.
- Inputs are synchronous to Clk100Mhz; no internal synchronizers.

Test Plan (CLK_DIV=4, BLANK_CYCLES=1 unless noted):
- Reset behaviour: hold rst_n = 0 for 3 cycles, release → seg = 8'hFF, an = 4'hF, and display stays dark for a full frame (16 cycles) because active digit_en = 0.
- Basic frame: load with digits = 16'h1234, dp_in = 4'b0000, digit_en = 4'hF.
  - After the next frame_tick, slot 0 shows an = 4'b1110 / seg = 8'h99 ("4") for cycles 2-4 of the slot.
  - Slot 1 shows an = 4'b1101 / seg = 8'hB0 ("3").
  - Slot 2 shows 8'hA4 ("2"); slot 3 shows 8'hF9 ("1").
  - Each slot has 1 cycle of an = 4'hF first.
- Decimal point and enable masks: digits = 16'hABCD, dp_in = 4'b0100, digit_en = 4'b0110.
  - Digits 0 and 3 stay an = 4'hF throughout their slots.
  - Digit 1 shows seg = 8'hC6 ("C").
  - Digit 2 shows seg = 8'h03 ("b" 83 with dp bit cleared).
- Tear-free update:
  - Display 16'h1111; mid-frame (during digit 1) load 16'h2222, then load 16'h3333 before the boundary.
  - Remaining digits of the current frame still show "1".
  - Next frame shows "3" (8'hB0) on all digits; "2" never appears.
- Load on the boundary cycle: assert load = 1 with 16'h0F0F exactly on the 3→0 wrap cycle → the very next slot 0 shows 8'h8E ("F"), and pending_valid = 0 afterwards.
- Reset mid-operation: assert rst_n = 0 while digit 2 is lit → an = 4'hF and seg = 8'hFF in the same timestep (no clock edge needed); after release, the display is dark until a new load, and frame_tick first pulses 16 cycles after release.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Scans four hex digits onto a common-anode 4-digit seven-segment display.
// Frames are double-buffered so updates land only on a frame boundary.
module seg_scan_driver #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        Clk100Mhz,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hexDecode(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      4'hF:    pattern = 7'h0E;
      default: pattern = 7'h7F;
    endcase
    return pattern;
  endfunction

  logic [PW-1:0] prescalerR;
  logic [1:0]    digitIdxR;
  logic [15:0]   activeDigitsR;
  logic [3:0]    activeDpR;
  logic [3:0]    activeEnR;
  logic [15:0]   pendDigitsR;
  logic [3:0]    pendDpR;
  logic [3:0]    pendEnR;
  logic          pendValidR;

  logic          slotWrapS;
  logic          frameEndS;
  logic          inBlankS;
  logic [3:0]    curNibbleS;
  logic [7:0]    segNextS;
  logic [3:0]    anNextS;

  assign slotWrapS = (prescalerR == PRESC_MAX);
  assign frameEndS = slotWrapS && (digitIdxR == 2'd3);
  assign inBlankS  = (prescalerR < BLANK_END);

  // Slot prescaler and digit index.
  always_ff @(posedge Clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      prescalerR <= '0;
      digitIdxR  <= 2'd0;
    end else if (slotWrapS) begin
      prescalerR <= '0;
      digitIdxR  <= digitIdxR + 2'd1;
    end else begin
      prescalerR <= prescalerR + PW'(1);
    end
  end

  // Frame-boundary pulse, visible the cycle after the 3->0 wrap.
  always_ff @(posedge Clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frameEndS;
    end
  end

  // Pending/active buffers; a load coinciding with the boundary bypasses pending.
  always_ff @(posedge Clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      activeDigitsR <= 16'h0000;
      activeDpR     <= 4'h0;
      activeEnR     <= 4'h0;
      pendDigitsR   <= 16'h0000;
      pendDpR       <= 4'h0;
      pendEnR       <= 4'h0;
      pendValidR    <= 1'b0;
    end else if (load && frameEndS) begin
      activeDigitsR <= digits;
      activeDpR     <= dp_in;
      activeEnR     <= digit_en;
      pendValidR    <= 1'b0;
    end else if (load) begin
      pendDigitsR   <= digits;
      pendDpR       <= dp_in;
      pendEnR       <= digit_en;
      pendValidR    <= 1'b1;
    end else if (frameEndS && pendValidR) begin
      activeDigitsR <= pendDigitsR;
      activeDpR     <= pendDpR;
      activeEnR     <= pendEnR;
      pendValidR    <= 1'b0;
    end else begin
      pendValidR    <= pendValidR;
    end
  end

  // Nibble selected by the current digit index.
  always_comb begin
    curNibbleS = 4'h0;
    case (digitIdxR)
      2'd0:    curNibbleS = activeDigitsR[3:0];
      2'd1:    curNibbleS = activeDigitsR[7:4];
      2'd2:    curNibbleS = activeDigitsR[11:8];
      2'd3:    curNibbleS = activeDigitsR[15:12];
      default: curNibbleS = 4'h0;
    endcase
  end

  // Next segment/anode drive: dark during blanking or for disabled digits.
  always_comb begin
    segNextS = 8'hFF;
    anNextS  = 4'hF;
    if (inBlankS) begin
      segNextS = 8'hFF;
      anNextS  = 4'hF;
    end else if (activeEnR[digitIdxR]) begin
      anNextS  = ~(4'b0001 << digitIdxR);
      segNextS = {~activeDpR[digitIdxR], hexDecode(curNibbleS)};
    end else begin
      segNextS = 8'hFF;
      anNextS  = 4'hF;
    end
  end

  // Registered display outputs; reset forces the display dark immediately.
  always_ff @(posedge Clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      an  <= 4'hF;
    end else begin
      seg <= segNextS;
      an  <= anNextS;
    end
  end

endmodule
